// File: rtl/cp0_reg.sv
// cp0_reg: Coprocessor-0 register file.
//   Receives the write-back CP0 write channel, supplies CP0 read data to the
//   execute stage, runs the Count/Compare timer and records exception state
//   reported by the memory stage.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   we_i/waddr_i/data_i      CP0 write channel from write-back
//   raddr_i / data_o         CP0 read register number / combinational read data
//   int_i                    external hardware interrupt lines (-> Cause.IP[7:2])
//   excepttype_i             exception report from memory stage (0 = none)
//   current_inst_addr_i      PC of the excepting instruction
//   is_in_delayslot_i        excepting instruction sits in a delay slot
//   count_o..prid_o          architectural register contents
//   timer_int_o              timer interrupt level, held until Compare is written
module cp0_reg #(
  parameter logic [31:0] PRID_VALUE   = 32'h004c0102,
  parameter logic [31:0] CONFIG_VALUE = 32'h00008000,
  parameter logic [31:0] STATUS_RESET = 32'h10000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  raddr_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  output logic [31:0] data_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] config_o,
  output logic [31:0] prid_o,
  output logic        timer_int_o
);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;
  localparam logic [4:0] REG_CONFIG  = 5'd16;

  // Software-writable Cause bits: IV[23], WP[22], IP[1:0] (bits 9:8).
  localparam logic [31:0] CAUSE_WR_MASK = 32'h00C0_0300;

  logic        exc_valid;
  logic        exc_eret;
  logic [4:0]  exc_code;
  logic [31:0] cause_merge;

  assign config_o = CONFIG_VALUE;
  assign prid_o   = PRID_VALUE;

  assign cause_merge = (cause_o & ~CAUSE_WR_MASK) | (data_i & CAUSE_WR_MASK);

  // Exception decode: the recognised report codes map to their ExcCode;
  // only the interrupt report (1) differs from its low five bits.
  always_comb begin
    exc_valid = 1'b0;
    exc_code  = 5'd0;
    exc_eret  = (excepttype_i == 32'h0000_000e);
    case (excepttype_i)
      32'h0000_0001: begin exc_valid = 1'b1; exc_code = 5'h00; end
      32'h0000_0008: begin exc_valid = 1'b1; exc_code = 5'h08; end
      32'h0000_000a: begin exc_valid = 1'b1; exc_code = 5'h0a; end
      32'h0000_000c: begin exc_valid = 1'b1; exc_code = 5'h0c; end
      32'h0000_000d: begin exc_valid = 1'b1; exc_code = 5'h0d; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_o     <= 32'd0;
      compare_o   <= 32'd0;
      status_o    <= STATUS_RESET;
      cause_o     <= 32'd0;
      epc_o       <= 32'd0;
      timer_int_o <= 1'b0;
    end else begin
      count_o <= (we_i && waddr_i == REG_COUNT) ? data_i : count_o + 32'd1;

      // A Compare write acknowledges the timer, even on a matching cycle.
      if (we_i && waddr_i == REG_COMPARE) begin
        compare_o   <= data_i;
        timer_int_o <= 1'b0;
      end else if (compare_o != 32'd0 && count_o == compare_o) begin
        timer_int_o <= 1'b1;
      end

      cause_o[15:10] <= int_i;

      // Exception/eret reports take priority over software writes to
      // Status, Cause and EPC on the same edge.
      if (exc_valid) begin
        status_o[1]  <= 1'b1;
        cause_o[6:2] <= exc_code;
        if (!status_o[1]) begin
          epc_o      <= is_in_delayslot_i ? current_inst_addr_i - 32'd4
                                          : current_inst_addr_i;
          cause_o[31] <= is_in_delayslot_i;
        end
      end else if (exc_eret) begin
        status_o[1] <= 1'b0;
      end else if (we_i) begin
        case (waddr_i)
          REG_STATUS: status_o <= data_i;
          REG_EPC:    epc_o    <= data_i;
          REG_CAUSE: begin
            cause_o[9:8]   <= data_i[9:8];
            cause_o[23:22] <= data_i[23:22];
          end
          default: ;
        endcase
      end
    end
  end

  // Read port with write-through so the execute stage sees a same-cycle
  // write-back result without a pipeline bubble.
  always_comb begin
    data_o = 32'd0;
    case (raddr_i)
      REG_COUNT:   data_o = (we_i && waddr_i == REG_COUNT)   ? data_i : count_o;
      REG_COMPARE: data_o = (we_i && waddr_i == REG_COMPARE) ? data_i : compare_o;
      REG_STATUS:  data_o = (we_i && waddr_i == REG_STATUS)  ? data_i : status_o;
      REG_CAUSE:   data_o = (we_i && waddr_i == REG_CAUSE)   ? cause_merge : cause_o;
      REG_EPC:     data_o = (we_i && waddr_i == REG_EPC)     ? data_i : epc_o;
      REG_PRID:    data_o = PRID_VALUE;
      REG_CONFIG:  data_o = CONFIG_VALUE;
      default:     data_o = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_reg.sv
// tb_cp0_reg: directed and randomized checks of cp0_reg against a
// behavioural model of the CP0 register rules.
module tb_cp0_reg;

  localparam logic [31:0] PRID   = 32'h004c0102;
  localparam logic [31:0] CONFIG = 32'h00008000;
  localparam logic [31:0] SRST   = 32'h10000000;
  localparam logic [31:0] CMASK  = 32'h00C0_0300;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] data_i;
  logic [4:0]  raddr_i;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i;
  logic [31:0] current_inst_addr_i;
  logic        is_in_delayslot_i;
  logic [31:0] data_o, count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o;
  logic        timer_int_o;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [31:0] m_count, m_compare, m_status, m_cause, m_epc;
  logic        m_timer;

  always #5 clk = ~clk;

  cp0_reg dut (
    .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .data_i(data_i),
    .raddr_i(raddr_i), .int_i(int_i), .excepttype_i(excepttype_i),
    .current_inst_addr_i(current_inst_addr_i), .is_in_delayslot_i(is_in_delayslot_i),
    .data_o(data_o), .count_o(count_o), .compare_o(compare_o), .status_o(status_o),
    .cause_o(cause_o), .epc_o(epc_o), .config_o(config_o), .prid_o(prid_o),
    .timer_int_o(timer_int_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_exc(input logic [31:0] t);
    return (t == 32'h1) || (t == 32'h8) || (t == 32'ha) || (t == 32'hc) || (t == 32'hd);
  endfunction

  function automatic logic [31:0] model_read();
    bit hit;
    hit = we_i && (waddr_i == raddr_i);
    case (raddr_i)
      5'd9:  return hit ? data_i : m_count;
      5'd11: return hit ? data_i : m_compare;
      5'd12: return hit ? data_i : m_status;
      5'd13: return hit ? ((m_cause & ~CMASK) | (data_i & CMASK)) : m_cause;
      5'd14: return hit ? data_i : m_epc;
      5'd15: return PRID;
      5'd16: return CONFIG;
      default: return 32'd0;
    endcase
  endfunction

  // Next-state of the architectural registers from the current inputs.
  task automatic model_step();
    logic [31:0] n_count, n_compare, n_status, n_cause, n_epc;
    logic        n_timer;
    logic [4:0]  code;
    if (rst) begin
      m_count = 0; m_compare = 0; m_status = SRST; m_cause = 0; m_epc = 0; m_timer = 0;
      return;
    end
    n_count   = m_count + 1;
    n_compare = m_compare;
    n_status  = m_status;
    n_cause   = m_cause;
    n_epc     = m_epc;
    n_timer   = m_timer;
    if (m_compare != 0 && m_count == m_compare) n_timer = 1;
    if (we_i && waddr_i == 9) n_count = data_i;
    if (we_i && waddr_i == 11) begin n_compare = data_i; n_timer = 0; end
    if (is_exc(excepttype_i)) begin
      code = (excepttype_i == 32'h1) ? 5'd0 : excepttype_i[4:0];
      if (m_status[1] == 1'b0) begin
        n_epc = is_in_delayslot_i ? current_inst_addr_i - 4 : current_inst_addr_i;
        n_cause[31] = is_in_delayslot_i;
      end
      n_status[1] = 1'b1;
      n_cause[6:2] = code;
    end else if (excepttype_i == 32'he) begin
      n_status[1] = 1'b0;
    end else if (we_i) begin
      if (waddr_i == 12) n_status = data_i;
      if (waddr_i == 14) n_epc = data_i;
      if (waddr_i == 13) n_cause = (m_cause & ~CMASK) | (data_i & CMASK);
    end
    n_cause[15:10] = int_i;
    m_count = n_count; m_compare = n_compare; m_status = n_status;
    m_cause = n_cause; m_epc = n_epc; m_timer = n_timer;
  endtask

  // One clock: check the combinational read, advance DUT and model, check state.
  task automatic tick();
    #1;
    chk("data_o", data_o, model_read());
    @(posedge clk);
    model_step();
    #1;
    chk("count", count_o, m_count);
    chk("compare", compare_o, m_compare);
    chk("status", status_o, m_status);
    chk("cause", cause_o, m_cause);
    chk("epc", epc_o, m_epc);
    chk("timer", {31'd0, timer_int_o}, {31'd0, m_timer});
    chk("config", config_o, CONFIG);
    chk("prid", prid_o, PRID);
  endtask

  task automatic set_in(input logic we, input logic [4:0] wa, input logic [31:0] d,
                        input logic [4:0] ra, input logic [31:0] et,
                        input logic [31:0] pc, input logic ds);
    we_i = we; waddr_i = wa; data_i = d; raddr_i = ra;
    excepttype_i = et; current_inst_addr_i = pc; is_in_delayslot_i = ds;
  endtask

  initial begin
    logic [4:0]  regs [8];
    logic [31:0] etab [8];
    int sel;
    regs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd3};
    etab = '{32'h1, 32'h8, 32'ha, 32'hc, 32'hd, 32'he, 32'h7, 32'h0};

    rst = 1'b1; int_i = 6'd0;
    set_in(0, 0, 0, 5'd12, 0, 0, 0);
    repeat (2) @(posedge clk);
    model_step();
    #1;
    rst = 1'b0;

    // Reset contents and read of Status/PRId/Config
    chk("rst_count", count_o, 32'd0);
    chk("rst_timer", {31'd0, timer_int_o}, 32'd0);
    chk("rd_status", data_o, 32'h10000000);
    raddr_i = 5'd15; #1; chk("rd_prid", data_o, PRID);
    raddr_i = 5'd16; #1; chk("rd_config", data_o, CONFIG);
    tick(); chk("count_1", count_o, 32'd1);
    tick(); chk("count_2", count_o, 32'd2);

    // Timer: Compare=20 written at count 5
    while (m_count != 32'd5) tick();
    set_in(1, 5'd11, 32'd20, 5'd11, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 5'd9, 0, 0, 0);
    while (m_count != 32'd20) tick();
    chk("timer_pre", {31'd0, timer_int_o}, 32'd0);
    tick();
    chk("timer_rise", {31'd0, timer_int_o}, 32'd1);
    set_in(1, 5'd9, 32'hFFFF_FFFE, 5'd9, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 5'd9, 0, 0, 0);
    tick(); tick();
    chk("count_wrap", count_o, 32'd0);
    chk("timer_wrap", {31'd0, timer_int_o}, 32'd1);
    set_in(1, 5'd11, 32'd40, 5'd11, 0, 0, 0);
    tick();
    chk("timer_clr", {31'd0, timer_int_o}, 32'd0);

    // Cause write mask
    set_in(1, 5'd13, 32'hFFFF_FFFF, 5'd13, 0, 0, 0);
    tick();
    chk("cause_mask", cause_o, 32'h00C0_0300);

    // Syscall from EXL=0, then overflow with EXL=1
    set_in(0, 0, 0, 5'd14, 32'h8, 32'h100, 0);
    tick();
    chk("sys_epc", epc_o, 32'h100);
    chk("sys_exl", {31'd0, status_o[1]}, 32'd1);
    chk("sys_code", {27'd0, cause_o[6:2]}, 32'h8);
    set_in(0, 0, 0, 5'd13, 32'hc, 32'h200, 1);
    tick();
    chk("ov_epc", epc_o, 32'h100);
    chk("ov_bd", {31'd0, cause_o[31]}, 32'd0);
    chk("ov_code", {27'd0, cause_o[6:2]}, 32'hc);

    // eret, then RI in a delay slot, then eret again
    set_in(0, 0, 0, 5'd12, 32'he, 0, 0);
    tick();
    set_in(0, 0, 0, 5'd14, 32'ha, 32'h304, 1);
    tick();
    chk("ri_epc", epc_o, 32'h300);
    chk("ri_bd", {31'd0, cause_o[31]}, 32'd1);
    set_in(0, 0, 0, 5'd12, 32'he, 0, 0);
    tick();
    chk("eret_exl", {31'd0, status_o[1]}, 32'd0);
    chk("eret_epc", epc_o, 32'h300);

    // Exception beats a same-cycle EPC write; write-through read of EPC
    set_in(1, 5'd14, 32'hDEAD, 5'd12, 32'h1, 32'h400, 0);
    tick();
    chk("int_epc", epc_o, 32'h400);
    set_in(1, 5'd14, 32'h55, 5'd14, 0, 0, 0);
    #1;
    chk("bypass_epc", data_o, 32'h55);
    tick();

    // Reset during an exception report discards it
    rst = 1'b1;
    set_in(0, 0, 0, 5'd14, 32'h8, 32'h500, 0);
    tick();
    chk("rst_exc_epc", epc_o, 32'd0);
    chk("rst_exc_status", status_o, SRST);
    rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      we_i = $urandom_range(0, 1);
      waddr_i = regs[$urandom_range(0, 7)];
      data_i = $urandom;
      raddr_i = ($urandom_range(0, 3) == 0) ? waddr_i : regs[$urandom_range(0, 7)];
      int_i = $urandom_range(0, 63);
      sel = $urandom_range(0, 15);
      excepttype_i = (sel < 8) ? etab[sel] : 32'h0;
      current_inst_addr_i = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      is_in_delayslot_i = $urandom_range(0, 1);
      if (excepttype_i != 0) we_i = 1'b0;
      if (we_i && waddr_i == 5'd11 && $urandom_range(0, 2) == 0)
        data_i = m_count + $urandom_range(1, 4);
      rst = ($urandom_range(0, 49) == 0);
      tick();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
